// File: rtl/sixbitmuladd_seq.sv
// Sequential shift-and-add multiply-accumulate: result = multiplicand * multiplier + addend.
// One multiplier bit per clock, LSB first, behind a start/busy/done handshake.
module sixbitmuladd_seq #(
   parameter int WIDTH = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   input  logic [WIDTH-1:0]     addend,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   result,
   output logic                 overflow
);

   localparam int RW = 2 * WIDTH;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [RW-1:0]    a_sh;
   logic [RW-1:0]    acc;
   logic [RW-1:0]    acc_next;
   logic [WIDTH-1:0] b_sh;
   logic [CW-1:0]    cnt;

   // a_sh holds A << i and b_sh[0] holds B[i] for the current iteration i = cnt.
   always_comb begin
      acc_next = acc + (b_sh[0] ? a_sh : '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         overflow <= 1'b0;
         a_sh     <= '0;
         b_sh     <= '0;
         acc      <= '0;
         cnt      <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh  <= {{WIDTH{1'b0}}, multiplicand};
                  b_sh  <= multiplier;
                  acc   <= {{WIDTH{1'b0}}, addend};
                  cnt   <= '0;
                  state <= RUN;
                  busy  <= 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            RUN: begin
               acc  <= acc_next;
               a_sh <= a_sh << 1;
               b_sh <= b_sh >> 1;
               cnt  <= cnt + CW'(1);
               // Result and overflow are only written at completion, so they hold through RUN.
               if (cnt == LAST) begin
                  result   <= acc_next;
                  overflow <= |acc_next[RW-1:WIDTH];
                  state    <= DONE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sixbitmuladd_seq.sv
// Directed self-checking bench for sixbitmuladd_seq; inputs driven and outputs sampled on negedge.
module tb_sixbitmuladd_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [5:0]  multiplicand;
   logic [5:0]  multiplier;
   logic [5:0]  addend;
   logic        busy;
   logic        done;
   logic [11:0] result;
   logic        overflow;

   int checks;
   int failures;

   sixbitmuladd_seq #(.WIDTH(6)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .multiplicand(multiplicand),
      .multiplier(multiplier),
      .addend(addend),
      .busy(busy),
      .done(done),
      .result(result),
      .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issues one operation and waits (bounded) for done; returns observed result, latency and busy count.
   task automatic do_op(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c,
                        output logic [11:0] r, output logic ovf, output int lat, output int bcnt);
      lat  = -1;
      bcnt = 0;
      r    = '0;
      ovf  = 1'b0;
      multiplicand = a;
      multiplier   = b;
      addend       = c;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int m = 0; m < 20; m++) begin
         if (done) begin
            lat = m;
            r   = result;
            ovf = overflow;
            break;
         end
         if (busy) bcnt++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0;
      multiplicand = '0; multiplier = '0; addend = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 12'd0 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: busy=%b done=%b result=%0d ovf=%b, required 0 0 0 0",
                  busy, done, result, overflow);
      end
      // Reset and start on the same edge: reset wins.
      start = 1'b1; multiplicand = 6'd7; multiplier = 6'd7;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_beats_start: busy=%b, required 0", busy);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_release_idle: busy=%b done=%b, required 0 0", busy, done);
      end
   endtask

   task automatic test_divider_inverse();
      logic [11:0] r; logic ovf; int lat; int bcnt;
      do_op(6'd7, 6'd7, 6'd1, r, ovf, lat, bcnt);
      checks++;
      if (r !== 12'd50 || ovf !== 1'b0) begin
         failures++;
         $display("FAIL div_inverse_result: result=%0d ovf=%b, required 50 0", r, ovf);
      end
      checks++;
      if (lat !== 6 || bcnt !== 6) begin
         failures++;
         $display("FAIL div_inverse_latency: lat=%0d busy_cycles=%0d, required 6 6", lat, bcnt);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL done_one_cycle: done=%b busy=%b, required 0 0", done, busy);
      end
   endtask

   task automatic test_max_and_zero();
      logic [11:0] r; logic ovf; int lat; int bcnt;
      do_op(6'd63, 6'd63, 6'd63, r, ovf, lat, bcnt);
      checks++;
      if (r !== 12'hFC0 || ovf !== 1'b1) begin
         failures++;
         $display("FAIL max_case: result=%0d ovf=%b, required 4032 1", r, ovf);
      end
      do_op(6'd0, 6'd45, 6'd5, r, ovf, lat, bcnt);
      checks++;
      if (r !== 12'd5 || ovf !== 1'b0) begin
         failures++;
         $display("FAIL zero_a: result=%0d ovf=%b, required 5 0", r, ovf);
      end
      checks++;
      if (lat !== 6) begin
         failures++;
         $display("FAIL zero_a_latency: lat=%0d, required 6", lat);
      end
      @(negedge clk);
   endtask

   task automatic test_busy_reject();
      int done_cnt; int first_done; int bcnt; logic [11:0] r;
      done_cnt = 0; first_done = -1; bcnt = 0; r = '0;
      multiplicand = 6'd13; multiplier = 6'd4; addend = 6'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int m = 0; m < 20; m++) begin
         if (m == 0) begin
            checks++;
            if (result !== 12'd5) begin
               failures++;
               $display("FAIL result_hold_in_run: result=%0d, required 5", result);
            end
         end
         if (done) begin
            done_cnt++;
            if (first_done < 0) begin first_done = m; r = result; end
         end
         if (busy) bcnt++;
         if (m == 2) begin
            start = 1'b1; multiplicand = 6'd63; multiplier = 6'd63;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      checks++;
      if (done_cnt !== 1 || first_done !== 6) begin
         failures++;
         $display("FAIL busy_reject_done: pulses=%0d at=%0d, required 1 at 6", done_cnt, first_done);
      end
      checks++;
      if (r !== 12'd55) begin
         failures++;
         $display("FAIL busy_reject_result: result=%0d, required 55", r);
      end
      checks++;
      if (bcnt !== 6) begin
         failures++;
         $display("FAIL busy_reject_busy: busy_cycles=%0d, required 6", bcnt);
      end
   endtask

   task automatic test_back_to_back();
      logic exp_busy;
      multiplicand = 6'd2; multiplier = 6'd3; addend = 6'd0; start = 1'b1;
      @(negedge clk);
      multiplicand = 6'd5; multiplier = 6'd5; addend = 6'd1;
      for (int m = 0; m <= 13; m++) begin
         exp_busy = (m != 6 && m != 13);
         checks++;
         if (busy !== exp_busy || done !== ~exp_busy) begin
            failures++;
            $display("FAIL b2b_handshake m=%0d: busy=%b done=%b, required %b %b",
                     m, busy, done, exp_busy, ~exp_busy);
         end
         if (m == 6) begin
            checks++;
            if (result !== 12'd6) begin
               failures++;
               $display("FAIL b2b_first_result: result=%0d, required 6", result);
            end
         end
         if (m == 13) begin
            checks++;
            if (result !== 12'd26 || overflow !== 1'b0) begin
               failures++;
               $display("FAIL b2b_second_result: result=%0d ovf=%b, required 26 0", result, overflow);
            end
            start = 1'b0;
         end
         @(negedge clk);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL b2b_idle_after: busy=%b done=%b, required 0 0", busy, done);
      end
   endtask

   task automatic test_reset_mid_op();
      logic [11:0] r; logic ovf; int lat; int bcnt; int dcnt;
      multiplicand = 6'd63; multiplier = 6'd63; addend = 6'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 12'd0 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_op: busy=%b done=%b result=%0d ovf=%b, required 0 0 0 0",
                  busy, done, result, overflow);
      end
      dcnt = 0;
      for (int m = 0; m < 10; m++) begin
         if (done || busy) dcnt++;
         @(negedge clk);
      end
      checks++;
      if (dcnt !== 0) begin
         failures++;
         $display("FAIL reset_mid_op_quiet: active_cycles=%0d, required 0", dcnt);
      end
      do_op(6'd3, 6'd3, 6'd0, r, ovf, lat, bcnt);
      checks++;
      if (r !== 12'd9 || ovf !== 1'b0 || lat !== 6) begin
         failures++;
         $display("FAIL after_reset_op: result=%0d ovf=%b lat=%0d, required 9 0 6", r, ovf, lat);
      end
      @(negedge clk);
   endtask

   task automatic test_sweep();
      logic [11:0] r; logic ovf; int lat; int bcnt;
      int expv; int c;
      for (int a = 0; a < 64; a++) begin
         for (int b = 0; b < 64; b++) begin
            c = (b > 0) ? b - 1 : 0;
            expv = a * b + c;
            do_op(6'(a), 6'(b), 6'(c), r, ovf, lat, bcnt);
            checks++;
            if (r !== 12'(expv) || ovf !== (expv > 63) || lat !== 6) begin
               failures++;
               $display("FAIL sweep a=%0d b=%0d c=%0d: result=%0d ovf=%b lat=%0d, required %0d %b 6",
                        a, b, c, r, ovf, lat, expv, (expv > 63));
            end
         end
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      @(negedge clk);
      test_reset();
      test_divider_inverse();
      test_max_and_zero();
      test_busy_reject();
      test_back_to_back();
      test_reset_mid_op();
      test_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
